// File: rtl/simon_game_engine.sv
// simon_game_engine
//   Simon-style memory game controller. Each round appends one random colour
//   to a stored pattern, plays the whole pattern back on show_color, then
//   checks the player's presses against it with a per-press timeout.
//   All timing runs on an internal tick enable derived from clk; no derived
//   clock is generated.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   one-cycle pulse, begins a new game from IDLE, OVER or WIN
//   rnd        in   random colour source, sampled while appending a step
//   btn_valid  in   one-cycle pulse, player pressed a button
//   btn_color  in   colour of the pressed button (valid with btn_valid)
//   show_color out  {1,0..0} = blank, otherwise {0, colour}
//   level      out  current pattern length
//   score      out  rounds completed in this game
//   buzzer     out  high during the loss alarm
//   game_over  out  high in OVER
//   win        out  high in WIN
module simon_game_engine #(
    parameter int COLOR_W     = 2,
    parameter int MAX_LEN     = 16,
    parameter int TICK_DIV    = 800000,
    parameter int SHOW_TICKS  = 20,
    parameter int GAP_TICKS   = 5,
    parameter int INPUT_TICKS = 50,
    parameter int BUZZ_TICKS  = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [COLOR_W-1:0]             rnd,
    input  logic                           btn_valid,
    input  logic [COLOR_W-1:0]             btn_color,
    output logic [COLOR_W:0]               show_color,
    output logic [$clog2(MAX_LEN+1)-1:0]   level,
    output logic [$clog2(MAX_LEN+1)-1:0]   score,
    output logic                           buzzer,
    output logic                           game_over,
    output logic                           win
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TA   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TB   = (INPUT_TICKS > BUZZ_TICKS) ? INPUT_TICKS : BUZZ_TICKS;
    localparam int TMAX = (TA > TB) ? TA : TB;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [COLOR_W:0] BLANK = {1'b1, {COLOR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPEND   = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_GAP = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_LOSE     = 3'd5,
        S_OVER     = 3'd6,
        S_WIN      = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q;
    logic                tick_s;
    logic [TW-1:0]       timer_q, timer_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       level_q, level_d;
    logic [LW-1:0]       score_q, score_d;
    logic                pat_we_s;
    logic [COLOR_W-1:0]  pattern_q [0:(2**AW)-1];
    logic [COLOR_W-1:0]  cur_color_s;
    logic                last_s;
    logic [COLOR_W:0]    show_color_q;
    logic                buzzer_q;
    logic                game_over_q;
    logic                win_q;

    assign tick_s      = (div_q == DW'(TICK_DIV - 1));
    assign cur_color_s = pattern_q[idx_q[AW-1:0]];
    // Position being shown/checked is the final step of the current pattern.
    assign last_s      = (idx_q == (level_q - LW'(1)));

    // Free-running tick divider: one-clk tick every TICK_DIV clks.
    always_ff @(posedge clk) begin
        if (reset || tick_s) begin
            div_q <= DW'(0);
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Pattern storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (pat_we_s && !reset) begin
            pattern_q[level_q[AW-1:0]] <= rnd;
        end
    end

    // Next-state logic for the game sequencer and its counters.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        level_d  = level_q;
        score_d  = score_q;
        pat_we_s = 1'b0;
        case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (start) begin
                    level_d = LW'(0);
                    score_d = LW'(0);
                    state_d = S_APPEND;
                end else begin
                    state_d = state_q;
                end
            end
            S_APPEND: begin
                pat_we_s = 1'b1;
                level_d  = level_q + LW'(1);
                idx_d    = LW'(0);
                timer_d  = TW'(0);
                state_d  = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tick_s && (timer_q == TW'(SHOW_TICKS - 1))) begin
                    timer_d = TW'(0);
                    state_d = S_SHOW_GAP;
                end else if (tick_s) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            S_SHOW_GAP: begin
                if (tick_s && (timer_q == TW'(GAP_TICKS - 1))) begin
                    timer_d = TW'(0);
                    if (last_s) begin
                        idx_d   = LW'(0);
                        state_d = S_WAIT_IN;
                    end else begin
                        idx_d   = idx_q + LW'(1);
                        state_d = S_SHOW_ON;
                    end
                end else if (tick_s) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            S_WAIT_IN: begin
                // A press is evaluated before the timeout so a press landing
                // on the expiry clk is still accepted.
                if (btn_valid) begin
                    timer_d = TW'(0);
                    if (btn_color != cur_color_s) begin
                        state_d = S_LOSE;
                    end else if (last_s) begin
                        score_d = score_q + LW'(1);
                        state_d = (level_q == LW'(MAX_LEN)) ? S_WIN : S_APPEND;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end else if (tick_s && (timer_q == TW'(INPUT_TICKS - 1))) begin
                    timer_d = TW'(0);
                    state_d = S_LOSE;
                end else if (tick_s) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            S_LOSE: begin
                if (tick_s && (timer_q == TW'(BUZZ_TICKS - 1))) begin
                    timer_d = TW'(0);
                    state_d = S_OVER;
                end else if (tick_s) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow state by one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= TW'(0);
            idx_q        <= LW'(0);
            level_q      <= LW'(0);
            score_q      <= LW'(0);
            show_color_q <= BLANK;
            buzzer_q     <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            level_q      <= level_d;
            score_q      <= score_d;
            show_color_q <= (state_q == S_SHOW_ON) ? {1'b0, cur_color_s} : BLANK;
            buzzer_q     <= (state_q == S_LOSE);
            game_over_q  <= (state_q == S_OVER);
            win_q        <= (state_q == S_WIN);
        end
    end

    assign show_color = show_color_q;
    assign level      = level_q;
    assign score      = score_q;
    assign buzzer     = buzzer_q;
    assign game_over  = game_over_q;
    assign win        = win_q;

endmodule

// File: doc/simon_game_engine.md
Name: simon_game_engine

Overview:
Parametrised Simon-style memory-game controller. Grows a random colour pattern one step per round and plays it back on the display/LED output. Checks player button presses against the stored pattern, with a per-press timeout. Reports score, level, win/lose status and drives a timed buzzer. Runs entirely in the clk domain using an internal tick enable; it does not generate a derived clock.

Parameters:
COLOR_W, 2, bits per colour code (2^COLOR_W colours)
MAX_LEN, 16, maximum pattern length; completing this round is a win
TICK_DIV, 800000, clk cycles per game tick
SHOW_TICKS, 20, ticks each colour is displayed
GAP_TICKS, 5, blank ticks between displayed colours
INPUT_TICKS, 50, ticks allowed per player press before timeout
BUZZ_TICKS, 10, ticks the buzzer sounds on loss

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a new game from IDLE, OVER or WIN
rnd  in  COLOR_W  random colour source, sampled in APPEND
btn_valid  in  1  one-cycle pulse; player pressed a button
btn_color  in  COLOR_W  colour of the pressed button, valid with btn_valid
show_color  out  COLOR_W+1  MSB=1 means blank (value 1 followed by zeros); otherwise {0, colour}
level  out  $clog2(MAX_LEN+1)  current pattern length
score  out  $clog2(MAX_LEN+1)  rounds completed in this game
buzzer  out  1  high during loss alarm
game_over  out  1  high in OVER
win  out  1  high in WIN

Behaviour:
- Reset (synchronous):
  - Outputs: show_color = blank, level = 0, score = 0, buzzer = 0, game_over = 0, win = 0.
  - Internal: state = IDLE, all counters = 0. Pattern RAM contents are don't-care.
- Tick generation:
  - Free-running divider asserts tick for 1 clk every TICK_DIV clks; divider cleared by reset.
  - All phase timers count ticks, not clks.
- IDLE: show blank. A start pulse clears level and score, then goes to APPEND.
- APPEND (1 clk):
  - pattern[level] <= rnd; level <= level+1; idx <= 0; phase timer <= 0.
  - Next state is SHOW_ON.
- SHOW_ON:
  - show_color = {0, pattern[idx]}.
  - After SHOW_TICKS ticks, go to SHOW_GAP.
- SHOW_GAP:
  - show_color = blank.
  - After GAP_TICKS ticks: if idx == level-1, go to WAIT_IN with idx <= 0 and timer cleared; else idx++ and go to SHOW_ON.
- WAIT_IN: show_color = blank. On btn_valid:
  - Match, idx == level-1: score <= score+1. Go to WIN if level == MAX_LEN, else APPEND.
  - Match, otherwise: idx++ and timer cleared.
  - Mismatch: go to LOSE.
  - Timeout: no press within INPUT_TICKS ticks goes to LOSE.
  - btn_valid and timeout expiry in the same clk: the button wins.
- Ignored inputs:
  - btn_valid is ignored in every state except WAIT_IN.
  - start is ignored in APPEND, SHOW_ON, SHOW_GAP, WAIT_IN and LOSE.
- LOSE: buzzer = 1 for BUZZ_TICKS ticks, then go to OVER.
- OVER: game_over = 1. Holds until start; start clears level/score and goes to APPEND.
- WIN: win = 1. Holds until start; start clears level/score and goes to APPEND.
- Output timing: all outputs are registered. Each output updates in the clk after the state change that causes it.
- Ranges: level stays within 0..MAX_LEN; score never exceeds MAX_LEN.
- Reset mid-game: immediate return to IDLE with all outputs at reset values; buzzer drops the same cycle.

Test Plan:
Sim parameters for all scenarios: TICK_DIV=2, SHOW_TICKS=3, GAP_TICKS=1, INPUT_TICKS=4, BUZZ_TICKS=2, MAX_LEN=3, COLOR_W=2.
- Round 1, correct: start with rnd=2 -> level=1; show_color=3'b010 for 6 clks then blank. Press btn_color=2 in WAIT_IN -> score=1, new APPEND.
- Full win: rnd sequence 2,0,3 with all presses correct -> win=1, score=3, level=3. A later start -> level=1, score=0, win=0.
- Wrong press: round 2 with pattern {2,0}, press 2 then 1 -> LOSE; buzzer high 4 clks, then game_over=1, score=1.
- Timeout: no press for 4 ticks in WAIT_IN -> LOSE. A press landing on the expiry clk with the correct colour -> accepted, no LOSE.
- Ignored inputs: btn_valid pulses during SHOW_ON and start pulses during WAIT_IN -> no state, score or idx change.
- Reset mid-SHOW_ON and mid-LOSE -> next clk: show_color=3'b100, buzzer=0, level=0, state IDLE.
